// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and the round-robin pick function for the 8:1 mux arbiter.
package mux8_arb_pkg;

   localparam int N_LANES = 8;
   localparam int SEL_W   = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // First requesting lane strictly after ptr, wrapping; ptr itself is checked last.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [N_LANES-1:0] req,
                                                input logic [SEL_W-1:0]   ptr);
      logic [SEL_W-1:0] win;
      logic [SEL_W-1:0] idx;
      logic             found;
      win   = '0;
      found = 1'b0;
      for (int i = 1; i <= N_LANES; i++) begin
         idx = ptr + SEL_W'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Lane/consumer bundle for mux8_rr_arbiter; timeout_err exists only with MUX8_ARB_TIMEOUT_EN.
interface mux8_rr_arbiter_if
   import mux8_arb_pkg::*;
#(
   parameter int DW = 8
);
   logic [N_LANES-1:0]    req;
   logic [N_LANES*DW-1:0] din;
   logic [N_LANES-1:0]    last;
   logic                  out_ready;
   logic [N_LANES-1:0]    gnt;
   logic [SEL_W-1:0]      sel;
   logic [DW-1:0]         dout;
   logic                  dout_valid;
   logic                  dout_last;
   logic                  busy;
`ifdef MUX8_ARB_TIMEOUT_EN
   logic                  timeout_err;

   modport master (
      output req, din, last, out_ready,
      input  gnt, sel, dout, dout_valid, dout_last, busy, timeout_err
   );
   modport slave (
      input  req, din, last, out_ready,
      output gnt, sel, dout, dout_valid, dout_last, busy, timeout_err
   );
`else
   modport master (
      output req, din, last, out_ready,
      input  gnt, sel, dout, dout_valid, dout_last, busy
   );
   modport slave (
      input  req, din, last, out_ready,
      output gnt, sel, dout, dout_valid, dout_last, busy
   );
`endif
endinterface

// File: rtl/mux8_rr_arbiter_datapath.sv
// 8:1 data multiplexer steered by the arbiter's registered select.
module mux8_datapath
   import mux8_arb_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [N_LANES*DW-1:0] din,
   input  logic [SEL_W-1:0]      sel,
   output logic [DW-1:0]         dout
);

   always_comb begin
      dout = din[sel*DW +: DW];
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin packet arbiter for an 8:1 mux; MUX8_ARB_TIMEOUT_EN adds an idle-beat watchdog.
//
// state | meaning
// IDLE  | no grant held; arbitrate among req on the next edge
// BUSY  | grant held on sel_q until its last beat is accepted
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   mux8_rr_arbiter_if.slave bus
);

   arb_state_e         state_q, state_d;
   logic [N_LANES-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [SEL_W-1:0]   win;
   logic               busy;
   logic               xfer;

`ifdef MUX8_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               terr_q, terr_d;
`endif

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mux8_rr_arbiter: TIMEOUT must be >= 1");
   end

   assign busy = (state_q == BUSY);
   assign xfer = busy & bus.req[sel_q] & bus.out_ready;
   assign win  = rr_pick(bus.req, ptr_q);

   assign bus.gnt        = gnt_q;
   assign bus.sel        = sel_q;
   assign bus.busy       = busy;
   assign bus.dout_valid = busy & bus.req[sel_q];
   assign bus.dout_last  = busy & bus.req[sel_q] & bus.last[sel_q];
`ifdef MUX8_ARB_TIMEOUT_EN
   assign bus.timeout_err = terr_q;
`endif

   mux8_datapath #(.DW(DW)) u_datapath (
      .din  (bus.din),
      .sel  (sel_q),
      .dout (bus.dout)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
`ifdef MUX8_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d    = BUSY;
               sel_d      = win;
               ptr_d      = win;
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
`ifdef MUX8_ARB_TIMEOUT_EN
               cnt_d      = CNT_W'(TIMEOUT);
`endif
            end
         end
         BUSY: begin
            if (xfer) begin
               if (bus.last[sel_q]) begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
`ifdef MUX8_ARB_TIMEOUT_EN
               cnt_d = CNT_W'(TIMEOUT);
            end else if (!bus.req[sel_q]) begin
               // Down-count idle beats; terminal count 1 is the TIMEOUT-th idle cycle.
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  gnt_d   = '0;
                  terr_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
`endif
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= SEL_W'(N_LANES - 1);
`ifdef MUX8_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
`ifdef MUX8_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`endif
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: cycle model plus directed packet scenarios.
module tb_mux8_rr_arbiter;

   localparam int DW = 8;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mux8_rr_arbiter_if #(.DW(DW)) bus_if();

   mux8_rr_arbiter #(.DW(DW), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model state: which lane holds the grant and who won last.
   bit m_busy = 0;
   int m_sel  = 0;
   int m_ptr  = 7;
   int m_pick;
   bit m_found;
`ifdef MUX8_ARB_TIMEOUT_EN
   int m_tcnt = 0;
   bit m_terr = 0;
   int n_terr = 0;
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0;
         m_sel  = 0;
         m_ptr  = 7;
`ifdef MUX8_ARB_TIMEOUT_EN
         m_tcnt = 0;
         m_terr = 0;
`endif
      end else begin
`ifdef MUX8_ARB_TIMEOUT_EN
         m_terr = 0;
`endif
         if (!m_busy) begin
            if (bus_if.req != 0) begin
               m_found = 0;
               for (int k = 1; k <= 8; k++) begin
                  m_pick = (m_ptr + k) % 8;
                  if (!m_found && bus_if.req[m_pick]) begin
                     m_sel   = m_pick;
                     m_found = 1;
                  end
               end
               m_ptr  = m_sel;
               m_busy = 1;
`ifdef MUX8_ARB_TIMEOUT_EN
               m_tcnt = 0;
`endif
            end
         end else begin
            if (bus_if.req[m_sel] && bus_if.out_ready) begin
               if (bus_if.last[m_sel]) m_busy = 0;
`ifdef MUX8_ARB_TIMEOUT_EN
               m_tcnt = 0;
`endif
            end
`ifdef MUX8_ARB_TIMEOUT_EN
            else if (!bus_if.req[m_sel]) begin
               m_tcnt++;
               if (m_tcnt == TO) begin
                  m_busy = 0;
                  m_terr = 1;
               end
            end
`endif
         end
      end
   end

   bit         chk_en    = 0;
   bit         prev_busy = 0;
   logic [7:0] exp_gnt;
   logic       exp_valid;
   int         glog[$];
   int         dlog[$];
   int         llog[$];

   always @(negedge clk) begin
      if (chk_en) begin
         exp_gnt   = m_busy ? (8'd1 << m_sel) : 8'd0;
         exp_valid = m_busy && bus_if.req[m_sel];
         check("gnt", bus_if.gnt, exp_gnt);
         check("sel", bus_if.sel, m_sel[2:0]);
         check("busy", bus_if.busy, m_busy);
         check("dout_valid", bus_if.dout_valid, exp_valid);
         check("dout_last", bus_if.dout_last, exp_valid && bus_if.last[m_sel]);
         if (exp_valid) check("dout", bus_if.dout, bus_if.din[m_sel*8 +: 8]);
`ifdef MUX8_ARB_TIMEOUT_EN
         check("timeout_err", bus_if.timeout_err, m_terr);
         if (bus_if.timeout_err) n_terr++;
`endif
         if (bus_if.busy && !prev_busy) glog.push_back(int'(bus_if.sel));
         if (bus_if.dout_valid && bus_if.out_ready) begin
            dlog.push_back(int'(bus_if.dout));
            llog.push_back(int'(bus_if.dout_last));
         end
         prev_busy = bus_if.busy;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int k, input logic [7:0] v);
      bus_if.din[k*8 +: 8] = v;
   endtask

   task automatic do_reset();
      rst              = 1'b1;
      bus_if.req       = '0;
      bus_if.last      = '0;
      bus_if.out_ready = 1'b1;
      step();
      rst = 1'b0;
      glog.delete();
      dlog.delete();
      llog.delete();
`ifdef MUX8_ARB_TIMEOUT_EN
      n_terr = 0;
`endif
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      rst              = 1'b1;
      bus_if.req       = '0;
      bus_if.last      = '0;
      bus_if.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) set_lane(k, 8'hA0 + 8'(k));
      step();
      step();
      chk_en = 1;
      check("rst_busy", bus_if.busy, 0);
      check("rst_gnt", bus_if.gnt, 8'h00);
      check("rst_sel", bus_if.sel, 3'd0);
      check("rst_valid", bus_if.dout_valid, 0);
      rst = 1'b0;

      // Two requesters, single-beat packets: 0, 7, 0 with a bubble between.
      bus_if.req  = 8'h81;
      bus_if.last = 8'hFF;
      step();
      check("t1_first_busy", bus_if.busy, 1);
      check("t1_first_sel", bus_if.sel, 3'd0);
      step();
      check("t1_bubble", bus_if.busy, 0);
      step();
      check("t1_second_sel", bus_if.sel, 3'd7);
      check("t1_second_gnt", bus_if.gnt, 8'h80);
      step();
      step();
      check("t1_third_sel", bus_if.sel, 3'd0);
      step();
      check("t1_glog_n", glog.size(), 3);
      check("t1_glog0", qget(glog, 0), 0);
      check("t1_glog1", qget(glog, 1), 7);
      check("t1_glog2", qget(glog, 2), 0);

      // All lanes requesting: strict rotation 0..7 then 0.
      do_reset();
      bus_if.req  = 8'hFF;
      bus_if.last = 8'hFF;
      repeat (18) step();
      check("t2_glog_n", glog.size(), 9);
      for (int i = 0; i < 9; i++) check($sformatf("t2_glog%0d", i), qget(glog, i), i % 8);

      // Lane 3 four-beat packet, lane 5 arrives mid-packet.
      do_reset();
      bus_if.req  = 8'h08;
      bus_if.last = 8'h00;
      set_lane(3, 8'h30);
      step();
      check("t3_grant", bus_if.sel, 3'd3);
      for (int b = 0; b < 4; b++) begin
         set_lane(3, 8'h30 + 8'(b));
         bus_if.last = (b == 3) ? 8'h08 : 8'h00;
         if (b == 2) bus_if.req = 8'h28;
         step();
         if (b < 3) check("t3_hold", bus_if.gnt, 8'h08);
      end
      check("t3_bubble", bus_if.busy, 0);
      bus_if.req  = 8'h20;
      bus_if.last = 8'h20;
      step();
      check("t3_lane5_sel", bus_if.sel, 3'd5);
      check("t3_lane5_busy", bus_if.busy, 1);
      step();
      bus_if.req = 8'h00;
      check("t3_dlog_n", dlog.size(), 5);
      for (int i = 0; i < 4; i++) check($sformatf("t3_data%0d", i), qget(dlog, i), 8'h30 + i);
      check("t3_data_l5", qget(dlog, 4), 8'hA5);
      check("t3_last_b0", qget(llog, 0), 0);
      check("t3_last_b3", qget(llog, 3), 1);

      // Lane 2 two-beat packet with back-pressure 1,0,0,1.
      do_reset();
      bus_if.req  = 8'h04;
      bus_if.last = 8'h00;
      step();
      for (int i = 0; i < 4; i++) begin
         bus_if.out_ready = (i == 0 || i == 3);
         bus_if.last      = (i == 0) ? 8'h00 : 8'h04;
         step();
         if (i < 3) begin
            check("t4_gnt_stable", bus_if.gnt, 8'h04);
            check("t4_sel_stable", bus_if.sel, 3'd2);
         end
      end
      bus_if.req       = 8'h00;
      bus_if.out_ready = 1'b1;
      check("t4_released", bus_if.busy, 0);
      check("t4_xfers", dlog.size(), 2);
      check("t4_last0", qget(llog, 0), 0);
      check("t4_last1", qget(llog, 1), 1);

      // Lane 6 stalls after one beat without last.
      do_reset();
      bus_if.req  = 8'h40;
      bus_if.last = 8'h00;
      step();
      step();
      bus_if.req = 8'h00;
`ifdef MUX8_ARB_TIMEOUT_EN
      repeat (15) step();
      check("t5_held_15", bus_if.busy, 1);
      step();
      check("t5_released_16", bus_if.busy, 0);
      check("t5_terr_pulse", bus_if.timeout_err, 1);
      step();
      check("t5_terr_clear", bus_if.timeout_err, 0);
      check("t5_terr_count", n_terr, 1);
`else
      repeat (20) step();
      check("t5_held_busy", bus_if.busy, 1);
      check("t5_held_gnt", bus_if.gnt, 8'h40);
`endif

      // Reset in the middle of a lane 4 packet.
      do_reset();
      bus_if.req  = 8'h10;
      bus_if.last = 8'h00;
      step();
      step();
      check("t6_mid_sel", bus_if.sel, 3'd4);
      rst = 1'b1;
      step();
      check("t6_rst_busy", bus_if.busy, 0);
      check("t6_rst_gnt", bus_if.gnt, 8'h00);
      rst = 1'b0;
      step();
      check("t6_regrant_busy", bus_if.busy, 1);
      check("t6_regrant_gnt", bus_if.gnt, 8'h10);

      do_reset();
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and sequencer for an 8:1 datapath multiplexer. It shares one output channel between 8 requesters, each sending a packet of one or more beats. It grants one requester at a time and holds the grant until that requester's last beat, driving the 3-bit mux select. It sits between 8 source lanes and a single downstream consumer with a valid/ready handshake.

Parameters:
DW, 8, data width of each lane and of dout
TIMEOUT, 16, idle-beat watchdog limit in cycles (used only with MUX8_ARB_TIMEOUT_EN; must be >= 1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  8  per-lane request/valid; bit k = lane k has a beat present
din  input  8*DW  lane k data on din[k*DW +: DW]
last  input  8  per-lane last-beat flag, qualified by req[k]
out_ready  input  1  downstream accepts a beat this cycle
gnt  output  8  one-hot grant, registered
sel  output  3  registered mux select = index of granted lane
dout  output  DW  din lane selected by sel (combinational 8:1 mux)
dout_valid  output  1  busy & req[sel]
dout_last  output  1  busy & req[sel] & last[sel]
busy  output  1  grant currently held

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst. All state updates occur on the rising clk edge.
- Reset values: gnt=0, sel=0, busy=0, ptr=7 (last winner), so lane 0 has top priority after reset. dout_valid and dout_last are 0 while busy=0.
- State machine has two states, IDLE and BUSY.
- IDLE with req==0: stay in IDLE.
- IDLE with req!=0: choose the first set bit scanning ptr+1, ptr+2, ... mod 8. Next edge: sel=winner, gnt=1<<winner, busy=1, ptr=winner, go to BUSY. Grant latency is 1 cycle from req.
- Beat transfer: busy & req[sel] & out_ready in the same cycle.
- BUSY, transfer with last[sel]=1: next edge gnt=0, busy=0, go to IDLE. This gives one bubble cycle before the next arbitration.
- BUSY, transfer with last=0, or no transfer: hold gnt and sel. The grant is sticky even if req[sel] drops mid-packet. dout_valid falls to 0 during such gaps.
- Requests on other lanes while BUSY: ignored, not lost. They are arbitrated at the next IDLE.
- Single requester with continuous packets: it is re-granted after each packet's bubble.
- Fairness: each lane waits at most 7 packets between grants.
- out_ready=0: no beat is consumed. The lane must hold din/last stable (source responsibility). The arbiter state does not change.
- Single-beat packet (req and last together): busy for exactly 1 cycle if out_ready=1.
- Reset mid-packet: grant is dropped immediately at the edge and ptr returns to 7. There is no partial-packet recovery.
- gnt is always one-hot or zero and always equals (busy ? 1<<sel : 0).
- dout is don't-care when dout_valid=0, but is still driven by the mux (no X/Z).

Optional Feature:
- Macro: MUX8_ARB_TIMEOUT_EN.
- Defined: a counter of log2(TIMEOUT)+1 bits is cleared on grant and on every transfer. It increments each BUSY cycle with req[sel]=0. On reaching TIMEOUT it forces release (BUSY to IDLE, gnt=0) and pulses output timeout_err (1 bit, reset 0) for one cycle.
- Not defined: no counter, no timeout_err port. The grant is held indefinitely until a last beat is transferred.

Decomposition:
- Package mux8_arb_pkg: N_LANES=8, SEL_W=3, state enum {IDLE, BUSY}, and a function rr_pick(req, ptr) returning the winner index.
- One natural sub-module: mux8_datapath (parameterised DW, 8 lanes, sel[2:0] -> dout), instantiated by the arbiter.
- The FSM, pointer and watchdog logic stay in the top level.

Test Plan:
- After rst, req=8'b1000_0001, single-beat packets, out_ready=1 -> grants lane 0 (sel=0) first, then lane 7, then lane 0; each grant 1 cycle after IDLE, with a 1-cycle bubble between grants.
- req=8'hFF, all lanes single-beat, out_ready=1 -> sel sequence 0,1,2,...,7,0 with no lane repeated within 8 grants.
- Lane 3 sends a 4-beat packet, lane 5 requests at beat 2 -> lane 5 not granted until cycle after lane 3's last beat; dout equals lane 3 data on all 4 beats.
- Lane 2 granted, out_ready toggles 1,0,0,1 -> exactly 2 transfers, gnt and sel stable throughout, dout_last asserted only on the final accepted beat.
- Lane 6 drops req after beat 1 (no last) for 20 cycles, macro defined, TIMEOUT=16 -> release after 16 idle cycles, timeout_err pulses once. Macro undefined -> grant still held at cycle 20.
- rst asserted while lane 4 is mid-packet -> next edge gnt=0, busy=0. With req=8'h10 still high, lane 4 is re-granted 1 cycle after rst deasserts.
